// File: rtl/mult_pkg.sv
// Shared constants, state encoding and iteration-count helper for the sequential multiplier.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  // Counter must hold N = 32 when one bit is retired per cycle.
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  // Number of CALC iterations for a given step width.
  function automatic int unsigned n_iter(input int unsigned step_bits);
    return WIDTH / step_bits;
  endfunction

endpackage

// File: rtl/neg64.sv
// 64-bit two's-complement negate: bitwise invert plus one.
module neg64 (
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  assign data_o = ~data_i + 64'd1;

endmodule

// File: rtl/mult32_seq.sv
// Sequential 32x32 multiplier, signed or unsigned, retiring STEP_BITS multiplier bits per cycle.
// Signed operands are multiplied as magnitudes; the sign is applied once in FIX.
module mult32_seq
  import mult_pkg::*;
#(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned N = n_iter(STEP_BITS);
  localparam logic [CNT_W-1:0] NLoad = CNT_W'(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        sign_q;
  logic [63:0] prod_q;
  logic [63:0] pp;

  logic [63:0] neg_a_in, neg_a_out;
  logic [63:0] neg_b_out;
  logic [31:0] mag_a, mag_b;
  logic        unused_neg_b;

  // A request is taken only from IDLE or DONE; anything during CALC/FIX is dropped.
  assign accept = START && (state_q == StIdle || state_q == StDone);

  // One negator serves both |A| (at accept) and the final negate (in FIX); they never overlap.
  assign neg_a_in = (state_q == StFix) ? acc_q : {32'b0, A};

  neg64 u_neg_a (
    .data_i (neg_a_in),
    .data_o (neg_a_out)
  );

  neg64 u_neg_b (
    .data_i ({32'b0, B}),
    .data_o (neg_b_out)
  );

  assign unused_neg_b = ^neg_b_out[63:32];

  // 0x80000000 negates to itself in the low 32 bits, which is the correct magnitude.
  assign mag_a = (SIGNED && A[31]) ? neg_a_out[31:0] : A;
  assign mag_b = (SIGNED && B[31]) ? neg_b_out[31:0] : B;

  // Sum of the shifted partial products for the next STEP_BITS multiplier bits.
  always_comb begin
    logic [31:0] bits;
    logic [63:0] term;
    pp   = '0;
    bits = mplier_q;
    term = mcand_q;
    for (int j = 0; j < int'(STEP_BITS); j++) begin
      if (bits[0]) pp = pp + term;
      bits = bits >> 1;
      term = term << 1;
    end
  end

  // Next-state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StCalc;
          cnt_d   = NLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath: operand latch, shift-add accumulation, and result write in FIX.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      prod_q   <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {32'b0, mag_a};
      mplier_q <= mag_b;
      sign_q   <= SIGNED & (A[31] ^ B[31]);
    end else if (state_q == StCalc) begin
      acc_q    <= acc_q + pp;
      mcand_q  <= mcand_q << STEP_BITS;
      mplier_q <= mplier_q >> STEP_BITS;
    end else if (state_q == StFix) begin
      prod_q <= sign_q ? neg_a_out : acc_q;
    end
  end

  assign HI   = prod_q[63:32];
  assign LO   = prod_q[31:0];
  assign BUSY = (state_q == StCalc) || (state_q == StFix);
  assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: three instances (STEP_BITS 1, 2, 4) share all inputs.
module tb_mult32_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a, b;
  logic [31:0] hi1, lo1, hi2, lo2, hi4, lo4;
  logic        busy1, done1, busy2, done2, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;
  int e1, e2, e4, c1, c2, c4;

  mult32_seq #(.STEP_BITS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
    .HI(hi1), .LO(lo1), .BUSY(busy1), .DONE(done1)
  );
  mult32_seq #(.STEP_BITS(2)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
    .HI(hi2), .LO(lo2), .BUSY(busy2), .DONE(done2)
  );
  mult32_seq #(.STEP_BITS(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
    .HI(hi4), .LO(lo4), .BUSY(busy4), .DONE(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Drive a request, let the accepting edge pass, then scramble inputs.
  task automatic start_op(input logic s, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    sgn   = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    sgn   = ~s;
    check_eq("busy_after_accept", 64'(busy1), 64'd1);
  endtask

  // Count edges after acceptance until each DONE; bounded at 40 edges.
  task automatic track(input bit stop_u1, input int repulse_at);
    e1 = 0; e2 = 0; e4 = 0; c1 = 0; c2 = 0; c4 = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == repulse_at) begin
        start = 1'b1;
        a     = 32'h0;
        b     = 32'h0;
      end else begin
        start = 1'b0;
      end
      if (done1) begin c1++; if (e1 == 0) e1 = e; end
      if (done2) begin c2++; if (e2 == 0) e2 = e; end
      if (done4) begin c4++; if (e4 == 0) e4 = e; end
      if (stop_u1 && c1 != 0) break;
    end
  endtask

  task automatic check_op(input string tag, input logic [63:0] exp);
    check_eq({tag, "_p1"}, {hi1, lo1}, exp);
    check_eq({tag, "_p2"}, {hi2, lo2}, exp);
    check_eq({tag, "_p4"}, {hi4, lo4}, exp);
    check_eq({tag, "_lat1"}, 64'(e1), 64'd33);
    check_eq({tag, "_lat2"}, 64'(e2), 64'd17);
    check_eq({tag, "_lat4"}, 64'(e4), 64'd9);
    check_eq({tag, "_ndone1"}, 64'(c1), 64'd1);
    check_eq({tag, "_ndone2"}, 64'(c2), 64'd1);
    check_eq({tag, "_ndone4"}, 64'(c4), 64'd1);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check_eq("reset_prod", {hi1, lo1}, 64'd0);
    check_eq("reset_busy", 64'(busy1), 64'd0);
    check_eq("reset_done", 64'(done1), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    track(1'b0, 0);
    check_op("u_max", 64'hFFFF_FFFE_0000_0001);

    start_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    track(1'b0, 0);
    check_op("s_m1x1", 64'hFFFF_FFFF_FFFF_FFFF);

    start_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    track(1'b0, 0);
    check_op("s_min2", 64'h4000_0000_0000_0000);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    track(1'b0, 0);
    check_op("s_minxm1", 64'h0000_0000_8000_0000);

    start_op(1'b0, 32'h8000_0000, 32'h0000_0002);
    track(1'b0, 0);
    check_op("u_msb", 64'h0000_0001_0000_0000);

    start_op(1'b1, 32'hFFFF_FFFB, 32'h0000_0000);
    track(1'b0, 0);
    check_op("s_negzero", 64'h0);

    // START re-pulsed with zero operands while all instances are busy.
    start_op(1'b0, 32'd7, 32'd6);
    track(1'b0, 3);
    check_op("busy_ignore", 64'h0000_0000_0000_002A);

    // Back-to-back: second request accepted in the DONE cycle of the first.
    start_op(1'b0, 32'd3, 32'd5);
    track(1'b1, 0);
    check_op("b2b_first", 64'h0000_0000_0000_000F);
    start_op(1'b1, 32'hFFFF_FFFB, 32'd2);
    track(1'b0, 0);
    check_op("b2b_second", 64'hFFFF_FFFF_FFFF_FFF6);

    // Reset between edges during CALC iteration 10.
    start_op(1'b0, 32'h0001_2345, 32'h0000_6789);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("rst_prod1", {hi1, lo1}, 64'd0);
    check_eq("rst_prod2", {hi2, lo2}, 64'd0);
    check_eq("rst_prod4", {hi4, lo4}, 64'd0);
    check_eq("rst_busy1", 64'(busy1), 64'd0);
    check_eq("rst_done1", 64'(done1), 64'd0);
    @(negedge clk);
    sgn   = 1'b0;
    a     = 32'd2;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_start_ignored", 64'(busy1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("rst_first_accept", 64'(busy1), 64'd1);
    track(1'b0, 0);
    check_op("rst_next", 64'h0000_0000_0000_0006);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
